countdown_timer: RTL and testbench

Loadable down-counter that consumes a start value over a valid/ready load port, then counts it down to zero and reports completion. It is the complement of the team's free-running 4-bit up counter. The up counter reports elapsed counts; this block is armed with a count and signals when that count has expired. It serves as the timeout/delay primitive for control logic in the same clock domain.

---
 rtl/countdown_pkg.sv | 18 +
 rtl/countdown_timer_if.sv | 28 ++
 rtl/countdown_timer_prescaler.sv | 30 +++
 rtl/countdown_timer.sv | 131 +++++++++++++
 tb/tb_countdown_timer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Purpose : shared types and default parameters for the countdown timer block.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package countdown_pkg;

    // Controller states: IDLE accepts loads; ARMED holds a loaded count until start;
    // RUN decrements on prescaler ticks; HOLD is RUN frozen by pause.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_PRESCALE = 1;

endpackage

// File: rtl/countdown_timer_if.sv
// Purpose : load/control/status bundle of the countdown timer.
// Latency : n/a (wires only).
// Backpressure : load_valid must be held by the master until load_ready is seen high.
// Ports   : master drives load_valid/load_value/start/pause/clear and observes
//           load_ready/count/busy/done; slave is the timer side.
interface countdown_timer_if #(
    parameter int WIDTH = countdown_pkg::DEFAULT_WIDTH
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             pause;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_value, start, pause, clear,
        input  load_ready, count, busy, done
    );

    modport slave (
        input  load_valid, load_value, start, pause, clear,
        output load_ready, count, busy, done
    );
endinterface

// File: rtl/countdown_timer_prescaler.sv
// Purpose : divides enabled clock cycles down to a one-cycle tick every PRESCALE cycles.
// Latency : tick is combinational from the phase register; the first tick after clr
//           is PRESCALE enabled cycles later.
// Backpressure : hold freezes the phase (and suppresses tick); clr returns phase to 0.
// Ports   : clk, rst (sync active-low), clr (phase restart), hold (freeze), tick (out).
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    // With PRESCALE=1 LAST is 0 and phase never leaves 0, so tick is simply !hold.
    assign tick = !hold && (phase == LAST);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            phase <= '0;
        end else if (!hold) begin
            phase <= tick ? '0 : phase + PW'(1);
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// Purpose : loadable down-counter; arms with a start value, counts to zero, pulses done.
// Latency : load visible next cycle; done is registered and lands load_value*PRESCALE
//           cycles after start (plus paused cycles).
// Backpressure : load_ready is high only in IDLE; loads offered elsewhere wait.
// Ports   : clk, rst (sync active-low), bus (countdown_timer_if.slave).
// Config  : define COUNTDOWN_AUTORELOAD_EN to reload the count from a shadow register
//           on expiry and keep running until clear/reset.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic              clk,
    input  logic              rst,
    countdown_timer_if.slave  bus
);
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             done_pulse;
    logic             done_nxt;
    logic             load_fire;
    logic             tick;
    logic             pre_clr;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] shadow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow <= '0;
        end else if (load_fire && !bus.clear) begin
            shadow <= bus.load_value;
        end
    end
`endif

    assign load_fire      = bus.load_valid && (state == IDLE);
    assign bus.load_ready = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.count      = cnt;
    assign bus.done       = done_pulse;

    // The phase only runs in RUN/HOLD; holding it cleared elsewhere means start
    // always begins a fresh PRESCALE interval. Freezing follows the pause level,
    // so the cycle leaving HOLD already counts toward the next tick.
    assign pre_clr = bus.clear || !((state == RUN) || (state == HOLD));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .hold (bus.pause),
        .tick (tick)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        if (bus.clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_fire) begin
                        cnt_nxt   = bus.load_value;
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (bus.start) begin
                        if (cnt == '0) begin
                            // Nothing to count: expire immediately without wrapping.
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN, HOLD: begin
                    if (bus.pause) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = RUN;
                        if (tick) begin
                            if (cnt > WIDTH'(1)) begin
                                cnt_nxt = cnt - WIDTH'(1);
                            end else begin
                                done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                                if (shadow != '0) begin
                                    cnt_nxt = shadow;
                                end else begin
                                    cnt_nxt   = '0;
                                    state_nxt = IDLE;
                                end
`else
                                cnt_nxt   = '0;
                                state_nxt = IDLE;
`endif
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            done_pulse <= done_nxt;
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (PRESCALE=1 and PRESCALE=3) share one
// stimulus stream and are compared each cycle against a behavioural model.
module tb_countdown_timer;
    localparam int W = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_HOLD  = 3;

    typedef struct {
        int st;
        int cnt;
        bit dn;
        int shadow;
        int el;
    } mstate_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_value;
    logic         start;
    logic         pause;
    logic         clear;

    int      n_err    = 0;
    int      n_checks = 0;
    bit      chk_en   = 1'b0;
    mstate_t m [2];

    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(W)) bus1 ();
    countdown_timer_if #(.WIDTH(W)) bus3 ();

    assign bus1.load_valid = load_valid;
    assign bus1.load_value = load_value;
    assign bus1.start      = start;
    assign bus1.pause      = pause;
    assign bus1.clear      = clear;
    assign bus3.load_valid = load_valid;
    assign bus3.load_value = load_value;
    assign bus3.start      = start;
    assign bus3.pause      = pause;
    assign bus3.clear      = clear;

    countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    countdown_timer #(.WIDTH(W), .PRESCALE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Next model state from the behavioural rules: elapsed unpaused RUN cycles
    // since start, a decrement each time that total reaches a multiple of p.
    function automatic mstate_t mnext(mstate_t c, int p);
        mstate_t n;
        n    = c;
        n.dn = 1'b0;
        if (!rst) begin
            n.st = M_IDLE; n.cnt = 0; n.el = 0; n.shadow = 0;
        end else if (clear) begin
            n.st = M_IDLE; n.cnt = 0; n.el = 0;
        end else if (c.st == M_IDLE) begin
            if (load_valid) begin
                n.st = M_ARMED; n.cnt = int'(load_value); n.shadow = int'(load_value);
            end
        end else if (c.st == M_ARMED) begin
            if (start) begin
                if (c.cnt == 0) begin
                    n.st = M_IDLE; n.dn = 1'b1;
                end else begin
                    n.st = M_RUN; n.el = 0;
                end
            end
        end else if (pause) begin
            n.st = M_HOLD;
        end else begin
            n.st = M_RUN;
            n.el = c.el + 1;
            if (n.el % p == 0) begin
                if (c.cnt > 1) begin
                    n.cnt = c.cnt - 1;
                end else begin
                    n.dn = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    if (c.shadow != 0) begin
                        n.cnt = c.shadow;
                    end else begin
                        n.cnt = 0; n.st = M_IDLE;
                    end
`else
                    n.cnt = 0; n.st = M_IDLE;
`endif
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m[0] <= mnext(m[0], 1);
        m[1] <= mnext(m[1], 3);
    end

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(string tag, int i, logic [W-1:0] cnt, logic busy,
                           logic done, logic rdy);
        check({tag, " count"}, int'(cnt), m[i].cnt);
        check({tag, " busy"}, int'(busy), int'(m[i].st != M_IDLE));
        check({tag, " done"}, int'(done), int'(m[i].dn));
        check({tag, " load_ready"}, int'(rdy), int'(m[i].st == M_IDLE));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut("dut1", 0, bus1.count, bus1.busy, bus1.done, bus1.load_ready);
            cmp_dut("dut3", 1, bus3.count, bus3.busy, bus3.done, bus3.load_ready);
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic do_load(int v);
        load_valid = 1'b1; load_value = W'(v); step(); load_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b0; load_valid = 1'b0; load_value = '0;
        start = 1'b0; pause = 1'b0; clear = 1'b0;
        step(2);
        chk_en = 1'b1;
        check("reset dut1 count", int'(bus1.count), 0);
        check("reset dut1 busy", int'(bus1.busy), 0);
        check("reset dut1 load_ready", int'(bus1.load_ready), 1);
        check("reset dut3 done", int'(bus3.done), 0);
        rst = 1'b1;
        step();

        // One-shot, PRESCALE=1: 5,4,3,2,1,0 with done and load_ready in the 0 cycle.
        do_load(5);
        check("load dut1 count", int'(bus1.count), 5);
        check("load dut1 busy", int'(bus1.busy), 1);
        do_start();
        check("start dut1 count", int'(bus1.count), 5);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("oneshot dut1 count", int'(bus1.count), 5 - k);
            check("oneshot dut1 done", int'(bus1.done), (k == 5) ? 1 : 0);
        end
        check("oneshot dut1 load_ready at done", int'(bus1.load_ready), 1);
        load_valid = 1'b1; load_value = W'(2);
        step();
        load_valid = 1'b0;
        check("reload-at-done dut1 count", int'(bus1.count), 2);
        check("reload-at-done dut1 done low", int'(bus1.done), 0);

        // Reset mid-RUN at count 3 discards the count and never pulses done.
        do_clear();
        do_load(5);
        do_start();
        step(2);
        check("pre-reset dut1 count", int'(bus1.count), 3);
        rst = 1'b0;
        step(2);
        check("midrun reset dut1 count", int'(bus1.count), 0);
        check("midrun reset dut1 busy", int'(bus1.busy), 0);
        check("midrun reset dut1 load_ready", int'(bus1.load_ready), 1);
        rst = 1'b1;
        step(6);

        // Pause, PRESCALE=3: 7 paused cycles after the first decrement.
        do_clear();
        do_load(4);
        do_start();
        check("pause dut3 count at start", int'(bus3.count), 4);
        step(3);
        check("pause dut3 first decrement", int'(bus3.count), 3);
        pause = 1'b1;
        step(7);
        pause = 1'b0;
        check("pause dut3 frozen count", int'(bus3.count), 3);
        check("pause dut3 busy", int'(bus3.busy), 1);
        t = 10;
        while (!bus3.done && t < 60) begin
            step();
            t++;
        end
        check("pause dut3 start-to-done cycles", t, 19);

        // Zero load: no decrement, done the cycle after start.
        do_clear();
        do_load(0);
        check("zero dut1 armed busy", int'(bus1.busy), 1);
        do_start();
        check("zero dut1 done", int'(bus1.done), 1);
        check("zero dut3 done", int'(bus3.done), 1);
        check("zero dut1 count", int'(bus1.count), 0);
        check("zero dut1 load_ready", int'(bus1.load_ready), 1);
        step();
        check("zero dut1 done low", int'(bus1.done), 0);

        // Loads offered while running are ignored; clear aborts without done.
        do_clear();
        do_load(5);
        do_start();
        load_valid = 1'b1; load_value = W'(9);
        step(3);
        check("busy-load dut1 count", int'(bus1.count), 2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear dut1 count", int'(bus1.count), 0);
        check("clear dut1 done", int'(bus1.done), 0);
        check("clear dut1 load_ready", int'(bus1.load_ready), 1);
        step();
        load_valid = 1'b0;
        check("post-clear load dut1 count", int'(bus1.count), 9);

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Auto-reload, PRESCALE=1: period of 3 cycles, busy never drops.
        do_clear();
        do_load(3);
        do_start();
        for (int k = 1; k <= 9; k++) begin
            step();
            check("reload dut1 done", int'(bus1.done), (k % 3 == 0) ? 1 : 0);
            check("reload dut1 busy", int'(bus1.busy), 1);
        end
        do_clear();
        check("reload clear dut1 busy", int'(bus1.busy), 0);
`endif

        step(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
